// File: rtl/flt_pkg.sv
// Shared float-core definitions: field widths, status bit positions, operand class
// encoding and the per-stage records of the float-to-int pipeline.
package flt_pkg;

    localparam int EXP_WIDTH      = 8;
    localparam int MAN_WIDTH      = 23;
    localparam int EXP_BIAS       = 127;

    localparam int TUSER_INVALID  = 1;
    localparam int TUSER_OVERFLOW = 0;
    localparam int TUSER_W        = 2;

    // Stream payloads are padded to whole bytes.
    function automatic int tdata_w(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    localparam int FLT_W = tdata_w(1 + EXP_WIDTH + MAN_WIDTH);
    localparam int RES_W = 32;

    // Aligned magnitude carries one headroom bit above the 32-bit result.
    localparam int MAG_W      = RES_W + 1;
    localparam int SHIFT_W    = 10;
    localparam int F2I_STAGES = 3;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } flt_cls_e;

    function automatic flt_cls_e flt_classify(input logic [EXP_WIDTH-1:0] e,
                                              input logic [MAN_WIDTH-1:0] m);
        if (e == '1) return (m != '0) ? NAN : INF;
        if (e == '0) return ZERO;
        return NORM;
    endfunction

    typedef struct packed {
        logic               sign;
        flt_cls_e           cls;
        logic [MAN_WIDTH:0] sig;
        logic [SHIFT_W-1:0] shift;
    } f2i_s1_t;

    typedef struct packed {
        logic             sign;
        flt_cls_e         cls;
        logic [MAG_W-1:0] mag;
        logic             guard;
        logic             sticky;
    } f2i_s2_t;

    typedef struct packed {
        logic [RES_W-1:0]   data;
        logic [TUSER_W-1:0] user;
    } f2i_res_t;

endpackage

// File: rtl/flt_f2i_align.sv
// Signed-shift barrel shifter: positive shift moves the significand right and
// collects guard/sticky, non-positive shift moves it left into the headroom bit.
module flt_f2i_align
    import flt_pkg::*;
(
    input  logic [MAN_WIDTH:0]         sig,
    input  logic signed [SHIFT_W-1:0]  shift,
    output logic [MAG_W-1:0]           mag,
    output logic                       guard,
    output logic                       sticky
);

    // Beyond 26 right shifts every significand bit lands in sticky.
    localparam int RSH_MAX = MAN_WIDTH + 3;
    localparam int LSH_MAX = MAG_W - 1 - MAN_WIDTH;
    localparam int RW      = MAN_WIDTH + 1 + RSH_MAX;

    localparam logic signed [SHIFT_W-1:0] RSH_LIM = SHIFT_W'(RSH_MAX);
    localparam logic signed [SHIFT_W-1:0] LSH_LIM = SHIFT_W'(LSH_MAX);

    logic [RW-1:0]            rwide;
    logic [MAG_W-1:0]         lwide;
    logic [4:0]               rsh;
    logic [3:0]               lsh;
    logic signed [SHIFT_W-1:0] nshift;

    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        rsh    = '0;
        lsh    = '0;
        rwide  = '0;
        lwide  = '0;
        nshift = -shift;
        if (shift > $signed(SHIFT_W'(0))) begin
            rsh    = (shift >= RSH_LIM) ? 5'(RSH_MAX) : shift[4:0];
            rwide  = {sig, {RSH_MAX{1'b0}}} >> rsh;
            mag    = MAG_W'(rwide[RW-1 -: MAN_WIDTH+1]);
            guard  = rwide[RSH_MAX-1];
            sticky = |rwide[RSH_MAX-2:0];
        end else if (nshift > LSH_LIM) begin
            // Too large to represent even with headroom; a set top bit forces saturation.
            mag = {1'b1, {(MAG_W-1){1'b0}}};
        end else begin
            lsh   = nshift[3:0];
            lwide = MAG_W'(sig) << lsh;
            mag   = lwide;
        end
    end

endmodule

// File: rtl/flt_f2i_pipe_core_only.sv
// Core-only wrapper for place-and-route; ports map one-to-one onto the converter.
module flt_f2i_pipe_core_only
    import flt_pkg::*;
#(
    parameter int RESULT_FRAC_BIT = 0
)
(
    input  logic               i_aclk,
    input  logic               i_areset,
    input  logic [FLT_W-1:0]   i_axi4s_a_tdata,
    input  logic               i_axi4s_a_tvalid,
    output logic [RES_W-1:0]   o_axi4s_result_tdata,
    output logic               o_axi4s_result_tvalid,
    output logic [TUSER_W-1:0] o_axi4s_result_tuser
);

    flt_f2i_pipe #(
        .RESULT_FRAC_BIT (RESULT_FRAC_BIT)
    ) u_core (
        .i_aclk                (i_aclk),
        .i_areset              (i_areset),
        .i_axi4s_a_tdata       (i_axi4s_a_tdata),
        .i_axi4s_a_tvalid      (i_axi4s_a_tvalid),
        .o_axi4s_result_tdata  (o_axi4s_result_tdata),
        .o_axi4s_result_tvalid (o_axi4s_result_tvalid),
        .o_axi4s_result_tuser  (o_axi4s_result_tuser)
    );

endmodule

// File: rtl/flt_f2i_pipe.sv
// Three-stage float32 to signed 32-bit fixed-point converter: round-to-nearest-even,
// saturation on overflow, NaN flagged as invalid. Valid-only stream, no backpressure.
module flt_f2i_pipe
    import flt_pkg::*;
#(
    parameter int RESULT_FRAC_BIT = 0
)
(
    input  logic               i_aclk,
    input  logic               i_areset,
    input  logic [FLT_W-1:0]   i_axi4s_a_tdata,
    input  logic               i_axi4s_a_tvalid,
    output logic [RES_W-1:0]   o_axi4s_result_tdata,
    output logic               o_axi4s_result_tvalid,
    output logic [TUSER_W-1:0] o_axi4s_result_tuser
);

    localparam int LAST = F2I_STAGES - 1;
    localparam logic [RES_W-1:0] POS_SAT = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [RES_W-1:0] NEG_SAT = {1'b1, {(RES_W-1){1'b0}}};

    logic [F2I_STAGES-1:0] vld_pipe;

    f2i_s1_t  s1_d, s1_q;
    f2i_s2_t  s2_d, s2_q;
    f2i_res_t res_d, res_q;

    // S1: unpack and classify; shift = bias + mantissa width - frac bits - exp.
    logic [EXP_WIDTH-1:0] a_exp;
    logic [MAN_WIDTH-1:0] a_man;

    always_comb begin
        a_exp      = i_axi4s_a_tdata[MAN_WIDTH +: EXP_WIDTH];
        a_man      = i_axi4s_a_tdata[MAN_WIDTH-1:0];
        s1_d.sign  = i_axi4s_a_tdata[EXP_WIDTH + MAN_WIDTH];
        s1_d.cls   = flt_classify(a_exp, a_man);
        s1_d.sig   = {1'b1, a_man};
        s1_d.shift = SHIFT_W'(EXP_BIAS + MAN_WIDTH - RESULT_FRAC_BIT)
                   - SHIFT_W'(a_exp);
    end

    // S2: alignment between the S1 and S2 registers.
    flt_f2i_align u_align (
        .sig    (s1_q.sig),
        .shift  ($signed(s1_q.shift)),
        .mag    (s2_d.mag),
        .guard  (s2_d.guard),
        .sticky (s2_d.sticky)
    );

    assign s2_d.sign = s1_q.sign;
    assign s2_d.cls  = s1_q.cls;

    // S3: round, negate, saturate. Overflow is judged on the rounded magnitude.
    logic                 inc;
    logic [MAG_W:0]       rnd;
    logic [RES_W-1:0]     rnd_lo;

    always_comb begin
        inc    = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);
        rnd    = {1'b0, s2_q.mag} + (MAG_W+1)'(inc);
        rnd_lo = rnd[RES_W-1:0];
        res_d  = '0;
        unique case (s2_q.cls)
            NAN: begin
                res_d.data                = NEG_SAT;
                res_d.user[TUSER_INVALID] = 1'b1;
            end
            INF: begin
                res_d.data                 = s2_q.sign ? NEG_SAT : POS_SAT;
                res_d.user[TUSER_OVERFLOW] = 1'b1;
            end
            NORM: begin
                if (s2_q.sign) begin
                    // -2^31 is representable, so the negative limit is one larger.
                    if (rnd > {2'b00, NEG_SAT}) begin
                        res_d.data                 = NEG_SAT;
                        res_d.user[TUSER_OVERFLOW] = 1'b1;
                    end else begin
                        res_d.data = -rnd_lo;
                    end
                end else begin
                    if (rnd > {2'b00, POS_SAT}) begin
                        res_d.data                 = POS_SAT;
                        res_d.user[TUSER_OVERFLOW] = 1'b1;
                    end else begin
                        res_d.data = rnd_lo;
                    end
                end
            end
            default: ;
        endcase
    end

    // Stage payloads load only under their own valid; no reset needed.
    always_ff @(posedge i_aclk) begin
        if (i_axi4s_a_tvalid) s1_q <= s1_d;
        if (vld_pipe[0])      s2_q <= s2_d;
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            vld_pipe <= '0;
            res_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAST-1:0], i_axi4s_a_tvalid};
            if (vld_pipe[LAST-1]) res_q <= res_d;
        end
    end

    assign o_axi4s_result_tdata  = res_q.data;
    assign o_axi4s_result_tuser  = res_q.user;
    assign o_axi4s_result_tvalid = vld_pipe[LAST];

endmodule

// File: tb/tb_flt_f2i_pipe.sv
// Directed bench for flt_f2i_pipe: integer (frac 0) and Q16.16 instances, hand-computed vectors.
module tb_flt_f2i_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a0_data  = '0;
    logic        a0_vld   = 1'b0;
    logic [31:0] r0_data;
    logic        r0_vld;
    logic [1:0]  r0_user;

    logic [31:0] a16_data = '0;
    logic        a16_vld  = 1'b0;
    logic [31:0] r16_data;
    logic        r16_vld;
    logic [1:0]  r16_user;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flt_f2i_pipe #(.RESULT_FRAC_BIT(0)) u_dut (
        .i_aclk                (clk),
        .i_areset              (rst),
        .i_axi4s_a_tdata       (a0_data),
        .i_axi4s_a_tvalid      (a0_vld),
        .o_axi4s_result_tdata  (r0_data),
        .o_axi4s_result_tvalid (r0_vld),
        .o_axi4s_result_tuser  (r0_user)
    );

    flt_f2i_pipe #(.RESULT_FRAC_BIT(16)) u_dut16 (
        .i_aclk                (clk),
        .i_areset              (rst),
        .i_axi4s_a_tdata       (a16_data),
        .i_axi4s_a_tvalid      (a16_vld),
        .o_axi4s_result_tdata  (r16_data),
        .o_axi4s_result_tvalid (r16_vld),
        .o_axi4s_result_tuser  (r16_user)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; result must show exactly three edges later.
    task automatic conv(input bit q16, input logic [31:0] a, input logic [31:0] ed,
                        input logic [1:0] eu, input string tag);
        if (q16) begin a16_data = a; a16_vld = 1'b1; end
        else     begin a0_data  = a; a0_vld  = 1'b1; end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            a0_vld  = 1'b0;
            a16_vld = 1'b0;
            if (k < 3) chk({tag, "/early"}, 32'(q16 ? r16_vld : r0_vld), 32'd0);
        end
        chk({tag, "/vld"},  32'(q16 ? r16_vld : r0_vld), 32'd1);
        chk({tag, "/data"}, q16 ? r16_data : r0_data, ed);
        chk({tag, "/user"}, 32'(q16 ? r16_user : r0_user), 32'(eu));
    endtask

    logic [31:0] st_a [20] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0800000, 32'h40A00000,
        32'h3FC00000, 32'h40200000, 32'h40600000, 32'hC0200000, 32'h42C80000,
        32'h447A0000, 32'hC47A0000, 32'h00000000, 32'h80000000, 32'h7F800000,
        32'h7FC00000, 32'h3E800000, 32'h3F400000, 32'h4B000000, 32'hBF800000};
    logic [31:0] st_d [20] = '{
        32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFC, 32'h00000005,
        32'h00000002, 32'h00000002, 32'h00000004, 32'hFFFFFFFE, 32'h00000064,
        32'h000003E8, 32'hFFFFFC18, 32'h00000000, 32'h00000000, 32'h7FFFFFFF,
        32'h80000000, 32'h00000000, 32'h00000001, 32'h00800000, 32'hFFFFFFFF};
    logic [1:0]  st_u [20] = '{
        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    bit vhist [48];
    int shist [48];

    initial begin
        // Reset with valid input asserted: must be ignored.
        a0_data = 32'h3F800000; a0_vld = 1'b1;
        a16_data = 32'h3F800000; a16_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/vld",   32'(r0_vld),   32'd0);
        chk("rst/data",  r0_data,       32'd0);
        chk("rst/user",  32'(r0_user),  32'd0);
        chk("rst16/vld", 32'(r16_vld),  32'd0);
        rst = 1'b0; a0_vld = 1'b0; a16_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst/ignored", 32'(r0_vld | r16_vld), 32'd0);
        end

        conv(0, 32'h3FC00000, 32'h00000002, 2'b00, "rnd 1.5");
        conv(0, 32'h40200000, 32'h00000002, 2'b00, "rnd 2.5");
        conv(0, 32'hBFC00000, 32'hFFFFFFFE, 2'b00, "rnd -1.5");
        @(posedge clk); #1;
        chk("hold/vld",  32'(r0_vld), 32'd0);
        chk("hold/data", r0_data,     32'hFFFFFFFE);

        conv(0, 32'h3F000000, 32'h00000000, 2'b00, "half 0.5");
        conv(0, 32'h3F000001, 32'h00000001, 2'b00, "half 0.5+");
        conv(0, 32'h3EFFFFFF, 32'h00000000, 2'b00, "half 0.5-");
        conv(0, 32'h00000001, 32'h00000000, 2'b00, "denorm");

        conv(0, 32'h4F000000, 32'h7FFFFFFF, 2'b01, "sat +2^31");
        conv(0, 32'hCF000000, 32'h80000000, 2'b00, "sat -2^31");
        conv(0, 32'hFF800000, 32'h80000000, 2'b01, "sat -inf");
        conv(0, 32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, "sat edge");
        conv(0, 32'h7F7FFFFF, 32'h7FFFFFFF, 2'b01, "sat maxflt");

        conv(0, 32'h7FC00000, 32'h80000000, 2'b10, "nan q");
        conv(0, 32'hFFFFFFFF, 32'h80000000, 2'b10, "nan neg");

        // Streaming with gaps: output valid pattern must be input pattern delayed 3.
        begin
            int si = 0;
            for (int c = 0; c < 48; c++) begin
                if (c >= 3) begin
                    chk("strm/vld", 32'(r0_vld), 32'(vhist[c-3]));
                    if (vhist[c-3]) begin
                        chk("strm/data", r0_data,      st_d[shist[c-3]]);
                        chk("strm/user", 32'(r0_user), 32'(st_u[shist[c-3]]));
                    end
                end
                vhist[c] = (si < 20) && pat[c % 7];
                shist[c] = si;
                a0_vld   = vhist[c];
                if (vhist[c]) begin
                    a0_data = st_a[si];
                    si++;
                end
                @(posedge clk); #1;
            end
        end

        // Reset with samples in flight: none may emerge.
        a0_data = 32'h3F800000; a0_vld = 1'b1;
        @(posedge clk); #1;
        a0_data = 32'h40000000;
        @(posedge clk); #1;
        a0_data = 32'h40400000; rst = 1'b1;
        @(posedge clk); #1;
        a0_vld = 1'b0;
        chk("midrst/vld",  32'(r0_vld), 32'd0);
        chk("midrst/data", r0_data,     32'd0);
        rst = 1'b0;
        conv(0, 32'h40A00000, 32'h00000005, 2'b00, "post rst");

        conv(1, 32'h3FC00000, 32'h00018000, 2'b00, "q16 1.5");
        conv(1, 32'h47000000, 32'h7FFFFFFF, 2'b01, "q16 32768");
        conv(1, 32'h37800000, 32'h00000001, 2'b00, "q16 2^-16");
        conv(1, 32'hC0200000, 32'hFFFD8000, 2'b00, "q16 -2.5");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
